// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants, state encoding and predecode helper for the fetch unit
package if_fetch_unit_pkg;

    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [6:0]  OPC_JALR         = 7'b1100111;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_REQ   = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic is_jump_op(input logic [31:0] inst);
        return (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR);
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry holding buffer for a fetched {pc, inst[, jjru]} payload
module fetch_hold_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic [W-1:0] r_data;
    logic         r_full;

    // Clear beats load so a redirect always empties the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF-stage PC owner, imem requester and IF/ID presenter; FETCH_PREDECODE_EN adds JAL/JALR predecode
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_out_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        is_jjru_o
);

`ifdef FETCH_PREDECODE_EN
    localparam int BUF_W = 65;
`else
    localparam int BUF_W = 64;
`endif

    fetch_state_t r_state, w_state_nx;
    logic [31:0]  r_pc, r_pc_out, r_inst;
    logic         r_valid;
    logic         w_capture, w_buf_load, w_buf_clear, w_present, w_bubble, w_redirect, w_pc_inc;
    logic [BUF_W-1:0] w_buf_din, w_buf_dout;
    logic         w_buf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FS_RESET;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_capture   = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;
        w_present   = 1'b0;
        w_bubble    = 1'b0;
        w_redirect  = 1'b0;
        w_pc_inc    = 1'b0;
        case (r_state)
            FS_RESET: w_state_nx = FS_REQ;
            FS_REQ: begin
                if (redirect_i) begin
                    w_redirect  = 1'b1;
                    w_buf_clear = 1'b1;
                end else if (imem_ack_i) begin
                    w_pc_inc = 1'b1;
                    if (stall_i) begin
                        w_buf_load = 1'b1;
                        w_state_nx = FS_HOLD;
                    end else begin
                        w_capture = 1'b1;
                    end
                end else if (!stall_i) begin
                    w_bubble = 1'b1;
                end
            end
            FS_HOLD: begin
                if (redirect_i) begin
                    w_redirect  = 1'b1;
                    w_buf_clear = 1'b1;
                    w_state_nx  = FS_REQ;
                end else if (!stall_i) begin
                    w_present   = 1'b1;
                    w_buf_clear = 1'b1;
                    w_state_nx  = FS_REQ;
                end
            end
            default: w_state_nx = FS_RESET;
        endcase
    end

`ifdef FETCH_PREDECODE_EN
    assign w_buf_din = {r_pc, imem_rdata_i, is_jump_op(imem_rdata_i)};
`else
    assign w_buf_din = {r_pc, imem_rdata_i};
`endif

    fetch_hold_buf #(.W(BUF_W)) u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_data  (w_buf_din),
        .o_data  (w_buf_dout),
        .o_full  (w_buf_full)
    );

    // Presented pc/inst only change on a real instruction; bubbles just drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_pc_out <= ZERO_WORD;
            r_inst   <= ZERO_WORD;
            r_valid  <= 1'b0;
        end else begin
            if (w_redirect)    r_pc <= redirect_pc_i & ~32'd3;
            else if (w_pc_inc) r_pc <= r_pc + 32'd4;

            if (w_capture) begin
                r_pc_out <= r_pc;
                r_inst   <= imem_rdata_i;
                r_valid  <= 1'b1;
            end else if (w_present) begin
                r_pc_out <= w_buf_dout[BUF_W-1 -: 32];
                r_inst   <= w_buf_dout[BUF_W-33 -: 32];
                r_valid  <= w_buf_full;
            end else if (w_redirect || w_bubble) begin
                r_valid  <= 1'b0;
            end
        end
    end

`ifdef FETCH_PREDECODE_EN
    logic r_jjru;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_jjru <= 1'b0;
        else if (w_capture) r_jjru <= is_jump_op(imem_rdata_i);
        else if (w_present) r_jjru <= w_buf_dout[0];
    end
    assign is_jjru_o = r_jjru;
`else
    assign is_jjru_o = 1'b0;
`endif

    assign imem_req_o  = (r_state == FS_REQ);
    assign imem_addr_o = r_pc;
    assign pc_out_o    = r_pc_out;
    assign inst_o      = r_inst;
    assign valid_o     = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed plus randomized bench for if_fetch_unit against a queue-based reference model
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_out_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        is_jjru_o;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_out_o      (pc_out_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o),
        .is_jjru_o     (is_jjru_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        j;
    } ent_t;

    ent_t        mbuf[$];
    logic        m_started;
    logic [31:0] m_pc, m_pco, m_inst;
    logic        m_valid, m_j;

`ifdef FETCH_PREDECODE_EN
    localparam logic JAL_EXPECT = 1'b1;
`else
    localparam logic JAL_EXPECT = 1'b0;
`endif

    function automatic logic exp_jjru(input logic [31:0] w);
`ifdef FETCH_PREDECODE_EN
        return (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h1357_9000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_pc      = 32'h0000_0000;
        m_pco     = 32'h0;
        m_inst    = 32'h0;
        m_valid   = 1'b0;
        m_j       = 1'b0;
        mbuf.delete();
    endtask

    // One clock: drive at edge+1, check request side before the edge, advance model, check presented side after.
    task automatic cyc(input logic st, input logic rd, input logic ak,
                       input logic [31:0] data, input logic [31:0] rpc);
        logic req;
        ent_t e;
        stall_i       = st;
        redirect_i    = rd;
        imem_ack_i    = ak;
        imem_rdata_i  = data;
        redirect_pc_i = rpc;
        req = m_started && (mbuf.size() == 0);
        chk("imem_req", {31'd0, imem_req_o}, {31'd0, req});
        if (req) chk("imem_addr", imem_addr_o, m_pc);
        @(posedge clk);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (rd) begin
            m_pc    = rpc & ~32'd3;
            m_valid = 1'b0;
            mbuf.delete();
        end else if (!req) begin
            if (!st) begin
                e       = mbuf.pop_front();
                m_pco   = e.pc;
                m_inst  = e.inst;
                m_j     = e.j;
                m_valid = 1'b1;
            end
        end else if (ak) begin
            e    = '{pc: m_pc, inst: data, j: exp_jjru(data)};
            m_pc = m_pc + 32'd4;
            if (st) begin
                mbuf.push_back(e);
            end else begin
                m_pco   = e.pc;
                m_inst  = e.inst;
                m_j     = e.j;
                m_valid = 1'b1;
            end
        end else if (!st) begin
            m_valid = 1'b0;
        end
        #1;
        chk("pc_out", pc_out_o, m_pco);
        chk("inst", inst_o, m_inst);
        chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
        chk("is_jjru", {31'd0, is_jjru_o}, {31'd0, m_j});
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ack_i = 1'b0; imem_rdata_i = '0;
        model_reset();
        #2;
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_pc_out", pc_out_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_jjru", {31'd0, is_jjru_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        cyc(0, 0, 1, mw(0), 0);
        cyc(0, 0, 1, mw(32'h0), 0);
        chk("seq_pc0", pc_out_o, 32'h0);
        cyc(0, 0, 1, mw(32'h4), 0);
        chk("seq_pc4", pc_out_o, 32'h4);
        chk("seq_valid", {31'd0, valid_o}, 32'd1);

        cyc(1, 0, 1, mw(32'h8), 0);
        cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
        cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
        chk("hold_keep_pc", pc_out_o, 32'h4);
        chk("hold_req", {31'd0, imem_req_o}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("release_pc", pc_out_o, 32'h8);
        chk("release_inst", inst_o, mw(32'h8));
        chk("release_req", {31'd0, imem_req_o}, 32'd1);
        chk("release_addr", imem_addr_o, 32'hC);

        cyc(1, 0, 1, mw(32'hC), 0);
        cyc(1, 1, 0, 0, 32'h0000_1003);
        chk("redir_valid", {31'd0, valid_o}, 32'd0);
        chk("redir_addr", imem_addr_o, 32'h0000_1000);

        cyc(0, 1, 0, 0, 32'h10);
        cyc(0, 0, 0, 0, 0);
        chk("noack_addr", imem_addr_o, 32'h10);
        cyc(0, 0, 0, 0, 0);
        chk("noack_valid", {31'd0, valid_o}, 32'd0);
        cyc(0, 0, 1, mw(32'h10), 0);
        chk("ack_pc10", pc_out_o, 32'h10);

        cyc(0, 0, 1, 32'h0000_006F, 0);
        chk("jal_predecode", {31'd0, is_jjru_o}, {31'd0, JAL_EXPECT});

        cyc(0, 1, 0, 0, 32'hFFFF_FFFE);
        chk("wrap_addr_hi", imem_addr_o, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 32'h1234_5600, 0);
        chk("wrap_addr_lo", imem_addr_o, 32'h0);

        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            if ($urandom_range(0, 99) < 25) d[6:0] = ($urandom_range(0, 1) == 1) ? 7'h6F : 7'h67;
            cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 70, d, $urandom);
        end

        cyc(0, 1, 0, 0, 32'h200);
        cyc(1, 0, 1, mw(32'h200), 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_pc_out", pc_out_o, 32'd0);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_req", {31'd0, imem_req_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 1, mw(0), 0);
        chk("post_rst_addr", imem_addr_o, 32'h0);
        cyc(0, 0, 1, mw(0), 0);
        chk("post_rst_pc", pc_out_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
